// File: rtl/pipe_stage_buf_pkg.sv
// Shared types for the pipeline stage buffer: occupancy update classification.
// Combinational helpers only; no state.
package pipe_stage_buf_pkg;

    typedef enum logic [1:0] {
        OP_HOLD = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_BOTH = 2'b11
    } occ_op_e;

    function automatic occ_op_e occ_op(input logic push, input logic pop);
        return occ_op_e'({pop, push});
    endfunction

endpackage

// File: rtl/pipe_buf_mem.sv
// DEPTH x WIDTH register array: one write port, one asynchronous read port.
// Write lands on the rising edge; synchronous clear has priority over the write.
module pipe_buf_mem #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned PW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             wr_en_i,
    input  logic [PW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic [PW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline stage: entry pushed at edge N is visible on out_data from edge N.
// in_ready depends only on registered occupancy, so out_ready never reaches it combinationally.
module pipe_stage_buf
    import pipe_stage_buf_pkg::*;
#(
    parameter int unsigned WIDTH             = 32,
    parameter int unsigned DEPTH             = 2,
    parameter bit          FLUSH_CLEARS_DATA = 1'b1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             squash, push, pop, mem_clr;
    logic [WIDTH-1:0] rd_data;

    assign squash    = RST || flush;
    assign in_ready  = (count_q < CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready && !squash;
    assign pop       = out_valid && out_ready && !squash;
    assign mem_clr   = squash && FLUSH_CLEARS_DATA;

    always_comb begin
        count_d = count_q;
        unique case (occ_op(push, pop))
            OP_PUSH: count_d = count_q + CW'(1);
            OP_POP:  count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers are power-of-two wide, so plain increment wraps modulo DEPTH.
    always_ff @(posedge CLK) begin
        if (squash) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
        end
    end

    pipe_buf_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_mem (
        .clk_i     (CLK),
        .clr_i     (mem_clr),
        .wr_en_i   (push),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (in_data),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (rd_data)
    );

    assign out_data = out_valid ? rd_data : '0;
    assign count    = count_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: default instance tracked by a FIFO scoreboard,
// plus a WIDTH=8/DEPTH=4 instance without data clearing on flush.
module tb_pipe_stage_buf;

    logic        CLK;
    int          checks = 0;
    int          errors = 0;

    logic        a_rst, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [31:0] a_in_data, a_out_data;
    logic [1:0]  a_count;

    logic        b_rst, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [7:0]  b_in_data, b_out_data;
    logic [2:0]  b_count;

    logic [31:0] sb[$];

    pipe_stage_buf #(.WIDTH(32), .DEPTH(2), .FLUSH_CLEARS_DATA(1'b1)) u_a (
        .CLK(CLK), .RST(a_rst), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .count(a_count)
    );

    pipe_stage_buf #(.WIDTH(8), .DEPTH(4), .FLUSH_CLEARS_DATA(1'b0)) u_b (
        .CLK(CLK), .RST(b_rst), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .count(b_count)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare DUT A against the scoreboard, then advance one edge and update the model.
    task automatic a_cycle(input string tag, output logic acc);
        logic [31:0] exp_data;
        logic [31:0] din;
        logic        squash, push, pop;
        int          n;
        n        = sb.size();
        exp_data = (n != 0) ? sb[0] : 32'h0;
        chk({tag, "_count"},    32'(a_count),     32'(n));
        chk({tag, "_out_valid"}, 32'(a_out_valid), 32'(n != 0));
        chk({tag, "_in_ready"},  32'(a_in_ready),  32'(n < 2));
        chk({tag, "_out_data"},  a_out_data,       exp_data);
        squash = a_rst || a_flush;
        push   = a_in_valid && (n < 2) && !squash;
        pop    = a_out_ready && (n != 0) && !squash;
        din    = a_in_data;
        @(posedge CLK);
        if (squash) begin
            sb.delete();
        end else begin
            if (pop)  void'(sb.pop_front());
            if (push) sb.push_back(din);
        end
        acc = push;
        #1;
    endtask

    task automatic b_step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic acc;
        int   v;

        a_rst = 1'b1; a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0; a_in_data = '0;
        b_rst = 1'b1; b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_data = '0;
        @(posedge CLK);
        #1;
        a_rst = 1'b0;

        // Reset state, then single push into empty stage.
        a_in_valid = 1'b1; a_in_data = 32'hA5A5_A5A5;
        a_cycle("single_push", acc);
        a_in_valid = 1'b0;
        a_cycle("single_seen", acc);
        a_out_ready = 1'b1;
        a_cycle("single_pop", acc);
        a_out_ready = 1'b0;

        // Fill to DEPTH, a refused third offer, then drain.
        a_in_valid = 1'b1; a_in_data = 32'h11;
        a_cycle("fill_11", acc);
        a_in_data = 32'h22;
        a_cycle("fill_22", acc);
        a_in_data = 32'h33;
        a_cycle("full_33", acc);
        chk("full_33_refused", 32'(acc), 32'd0);
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        a_cycle("drain_11", acc);
        a_cycle("drain_22", acc);
        a_cycle("drain_empty", acc);
        a_out_ready = 1'b0;

        // Full stage, streaming with both sides active.
        a_in_valid = 1'b1; a_in_data = 32'd100;
        a_cycle("stream_fill0", acc);
        a_in_data = 32'd101;
        a_cycle("stream_fill1", acc);
        a_out_ready = 1'b1;
        v = 0;
        for (int i = 0; i < 40 && v < 10; i++) begin
            a_in_data = 32'(v);
            a_cycle("stream", acc);
            if (acc) v++;
        end
        chk("stream_accepted", 32'(v), 32'd10);
        a_in_valid = 1'b0;
        for (int i = 0; i < 3; i++) a_cycle("stream_drain", acc);
        a_out_ready = 1'b0;

        // Flush beats a simultaneous push and pop.
        a_in_valid = 1'b1; a_in_data = 32'h40;
        a_cycle("fl_fill0", acc);
        a_in_data = 32'h41;
        a_cycle("fl_fill1", acc);
        a_flush = 1'b1; a_out_ready = 1'b1; a_in_data = 32'hDEAD_BEEF;
        a_cycle("fl_assert", acc);
        a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0;
        a_cycle("fl_after", acc);

        // Held flush blocks pushes.
        a_flush = 1'b1; a_in_valid = 1'b1; a_in_data = 32'h5151;
        for (int i = 0; i < 3; i++) a_cycle("fl_hold", acc);
        a_flush = 1'b0; a_in_valid = 1'b0;
        a_cycle("fl_hold_after", acc);

        // Reset together with flush and push while one entry is held.
        a_in_valid = 1'b1; a_in_data = 32'h77;
        a_cycle("rst_fill", acc);
        a_rst = 1'b1; a_flush = 1'b1; a_in_data = 32'h88;
        a_cycle("rst_assert", acc);
        a_rst = 1'b0; a_flush = 1'b0; a_in_valid = 1'b0;
        a_cycle("rst_after", acc);
        chk("rst_after_out_data", a_out_data, 32'h0);

        // Instance B: flush keeps stale storage yet presents only new data.
        b_rst = 1'b0;
        b_in_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            b_in_data = 8'(i);
            b_step();
        end
        b_in_valid = 1'b0;
        chk("b_full_count",    32'(b_count),    32'd4);
        chk("b_full_in_ready", 32'(b_in_ready), 32'd0);
        chk("b_full_head",     32'(b_out_data), 32'h01);
        b_flush = 1'b1;
        b_step();
        b_flush = 1'b0;
        chk("b_flushed_count",    32'(b_count),    32'd0);
        chk("b_flushed_out_data", 32'(b_out_data), 32'h0);
        b_in_valid = 1'b1; b_in_data = 8'h55;
        b_step();
        b_in_valid = 1'b0;
        chk("b_new_out_data",  32'(b_out_data),  32'h55);
        chk("b_new_count",     32'(b_count),     32'd1);
        chk("b_new_out_valid", 32'(b_out_valid), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 Parameter WIDTH, default 32, payload width in bits, 1..256.
REQ-002 Parameter DEPTH, default 2, entry count, power of two, 2..16.
REQ-003 Parameter FLUSH_CLEARS_DATA, default 1: 1 = flush and reset zero all storage; 0 = flush clears occupancy only.
REQ-004 CLK  input  1  single clock; all state updates on its rising edge.
REQ-005 RST  input  1  synchronous, active-high reset.
REQ-006 flush  input  1  synchronous squash of all held entries.
REQ-007 in_valid  input  1  upstream offers in_data this cycle.
REQ-008 in_ready  output  1  stage accepts in_data this cycle.
REQ-009 in_data  input  WIDTH  upstream payload.
REQ-010 out_valid  output  1  out_data holds a valid entry.
REQ-011 out_ready  input  1  downstream consumes out_data this cycle.
REQ-012 out_data  output  WIDTH  oldest held entry.
REQ-013 count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Function
REQ-014 Push occurs on a rising edge where in_valid && in_ready && !flush && !RST.
REQ-015 Pop occurs on a rising edge where out_valid && out_ready && !flush && !RST.
REQ-016 in_ready SHALL equal (count < DEPTH), with no combinational path from out_ready.
REQ-017 out_valid SHALL equal (count != 0).
REQ-018 out_data SHALL equal the entry at the read pointer when count != 0, and all-zero when count == 0.
REQ-019 Latency: an entry pushed into an empty stage at edge N is presented on out_data from edge N onward, one cycle after in_data was driven.
REQ-020 Order: entries leave in strict FIFO order; no entry is duplicated or lost except by flush or reset.
REQ-021 Push without pop: count+1. Pop without push: count-1. Push and pop in the same cycle: count unchanged, both pointers advance.
REQ-022 A full stage with out_ready=1 pops but does not push in that cycle; in_ready rises the following cycle.
REQ-023 in_valid while in_ready=0 is ignored; the upstream holds in_data stable until accepted.
REQ-024 out_ready while out_valid=0 is ignored; count never underflows.
REQ-025 Read and write pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
REQ-026 Flush has priority over push and pop in the same cycle.
- count, read pointer and write pointer go to 0.
- Storage is zeroed when FLUSH_CLEARS_DATA=1.
REQ-027 When flush is asserted, out_valid is 0 from the next cycle; in_ready is 1 from the next cycle.
REQ-028 A flush held for several cycles keeps the stage empty and blocks all pushes.

Reset
REQ-029 RST applies the flush behaviour of REQ-026 unconditionally, and has priority over flush.
REQ-030 After reset: count=0, out_valid=0, in_ready=1, out_data=0.
REQ-031 Storage is zeroed on reset when FLUSH_CLEARS_DATA=1.
REQ-032 Reset asserted mid-transfer discards every held entry and any push or pop in that cycle.

Structure
REQ-033 No new typedefs in cpu_types_pkg; WIDTH and DEPTH are per-instance parameters.
REQ-034 Existing pipeline latches are re-expressed as instances, with WIDTH set to the packed control and data bundle width and DEPTH=2.
REQ-035 One sub-module, pipe_buf_mem:
- DEPTH x WIDTH register array.
- One write port, one asynchronous read port.
- Synchronous clear input.
REQ-036 Occupancy, pointer and handshake logic live in pipe_stage_buf.

Verification
REQ-037 Reset, then push 0xA5A5A5A5 with out_ready=0 -> next cycle out_valid=1, out_data=0xA5A5A5A5, count=1.
REQ-038 DEPTH=2, out_ready=0, push 0x11 then 0x22 -> count=2, in_ready=0; a third in_valid=1 with 0x33 is not accepted; pops then yield 0x11, 0x22 only.
REQ-039 Full stage, in_valid=1 and out_ready=1 held for 10 cycles with incrementing data 0..9 -> outputs appear in order with no gaps or duplicates; count oscillates no lower than 1; pointers wrap at least twice.
REQ-040 count=2, assert flush together with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, out_data=0; the pushed value never appears on out_data.
REQ-041 count=1, assert RST and flush together with in_valid=1 -> next cycle all outputs at reset values, in_ready=1.
REQ-042 FLUSH_CLEARS_DATA=0, WIDTH=8, DEPTH=4: fill with 0x01..0x04, flush, push 0x55 -> out_data=0x55 and count=1.
